fir_tap_sequencer: RTL

- Sequencer for one output sample of the 64-tap, 16-bit FIR.
- Per sample it:
  - pops one input word from the sample FIFO;
  - commands a single shift of the input delay-line memory;
  - issues 64 consecutive read strobes to that memory;
  - drives coefficient address and MAC control aligned to the memory's registered serial output;
  - flags result completion.
- Sits between the input FIFO, the delay-line memory, the coefficient ROM and the MAC.

---
 rtl/fir_tap_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fir_tap_sequencer.sv
// Per-sample sequencer for the 64-tap FIR: FIFO pop, one delay-line shift, TAPS reads, MAC control.
// Optional shift-acknowledge timeout is enabled by defining SEQ_TIMEOUT_EN.
module fir_tap_sequencer #(
  parameter int TAPS        = 64,
  parameter int MAC_LAT     = 1,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  output logic                    shift_enable,
  input  logic                    shift_done,
  output logic                    start,
  input  logic                    read_done,
  output logic [$clog2(TAPS)-1:0] coef_addr,
  output logic                    mac_clr,
  output logic                    mac_en,
  output logic                    result_valid,
  output logic                    busy,
  output logic                    align_err,
  output logic [15:0]             sample_cnt
`ifdef SEQ_TIMEOUT_EN
  ,
  output logic                    timeout_err
`endif
);

  localparam int TAW = $clog2(TAPS);
  localparam int DW  = $clog2(MAC_LAT + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_SHIFT,
    S_WAIT_SHIFT,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [TAW-1:0]  tap_cnt_q, tap_cnt_d;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
  logic            align_err_q, align_err_d;
  logic [15:0]     sample_cnt_q, sample_cnt_d;
  logic            fifo_rd_en_q, fifo_rd_en_d;
  logic            shift_enable_q, shift_enable_d;
  logic            start_q, start_d;
  logic [TAW-1:0]  coef_addr_q, coef_addr_d;
  logic            mac_clr_q, mac_clr_d;
  logic            mac_en_q, mac_en_d;
  logic            result_valid_q, result_valid_d;
  logic            busy_q, busy_d;

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic            timeout_err_q, timeout_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    tap_cnt_d   = '0;
    drain_cnt_d = '0;
    align_err_d = align_err_q;
`ifdef SEQ_TIMEOUT_EN
    to_cnt_d      = '0;
    timeout_err_d = timeout_err_q;
`endif
    unique case (state_q)
      S_IDLE:  if (en && !fifo_empty) state_d = S_POP;
      S_POP:   state_d = S_SHIFT;
      S_SHIFT: state_d = S_WAIT_SHIFT;
      S_WAIT_SHIFT: begin
        if (shift_done) begin
          state_d = S_READ;
`ifdef SEQ_TIMEOUT_EN
        end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d       = S_IDLE;
          timeout_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
`endif
        end
      end
      S_READ: begin
        tap_cnt_d = tap_cnt_q + TAW'(1);
        if (tap_cnt_q == TAW'(TAPS - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q + DW'(1);
        // First drain cycle is the one right after the last read strobe.
        if (drain_cnt_q == '0 && !read_done) align_err_d = 1'b1;
        if (drain_cnt_q == DW'(MAC_LAT)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with the registered state.
    fifo_rd_en_d   = (state_d == S_POP);
    shift_enable_d = (state_d == S_SHIFT);
    start_d        = (state_d == S_READ);
    result_valid_d = (state_d == S_DONE);
    busy_d         = (state_d != S_IDLE);
    sample_cnt_d   = sample_cnt_q + 16'(state_d == S_DONE);
    mac_en_d       = start_q;
    mac_clr_d      = start_q && (tap_cnt_q == '0);
    coef_addr_d    = start_q ? tap_cnt_q : coef_addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      tap_cnt_q      <= '0;
      drain_cnt_q    <= '0;
      align_err_q    <= 1'b0;
      sample_cnt_q   <= '0;
      fifo_rd_en_q   <= 1'b0;
      shift_enable_q <= 1'b0;
      start_q        <= 1'b0;
      coef_addr_q    <= '0;
      mac_clr_q      <= 1'b0;
      mac_en_q       <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      to_cnt_q       <= '0;
      timeout_err_q  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      tap_cnt_q      <= tap_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      align_err_q    <= align_err_d;
      sample_cnt_q   <= sample_cnt_d;
      fifo_rd_en_q   <= fifo_rd_en_d;
      shift_enable_q <= shift_enable_d;
      start_q        <= start_d;
      coef_addr_q    <= coef_addr_d;
      mac_clr_q      <= mac_clr_d;
      mac_en_q       <= mac_en_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
`ifdef SEQ_TIMEOUT_EN
      to_cnt_q       <= to_cnt_d;
      timeout_err_q  <= timeout_err_d;
`endif
    end
  end

  assign fifo_rd_en   = fifo_rd_en_q;
  assign shift_enable = shift_enable_q;
  assign start        = start_q;
  assign coef_addr    = coef_addr_q;
  assign mac_clr      = mac_clr_q;
  assign mac_en       = mac_en_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign align_err    = align_err_q;
  assign sample_cnt   = sample_cnt_q;
`ifdef SEQ_TIMEOUT_EN
  assign timeout_err  = timeout_err_q;
`endif

endmodule
